// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing the async FIFO write port among NUM_REQ producers.
// Owns the binary/Gray write pointer and the registered full flag in the write clock domain.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no owner; search valid requesters upward from rr_ptr
// ST_LOCKED | grant held by grant_q until its last beat is written
module fifo_wr_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4,
    parameter int NUM_REQ   = 4,
    parameter int REQ_ID_W  = 2
) (
    input  logic                           i_wr_clk,
    input  logic                           i_wr_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ-1:0]             i_req_last,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [ADDR_SIZE:0]             i_rd_gray_sync,
    output logic                           o_wr_en,
    output logic [DATA_SIZE-1:0]           o_wr_data,
    output logic [ADDR_SIZE-1:0]           o_wr_addr,
    output logic [ADDR_SIZE:0]             o_wr_gray,
    output logic                           o_full,
    output logic [REQ_ID_W-1:0]            o_grant_id,
    output logic                           o_busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [REQ_ID_W-1:0]    grant_q, grant_d;
    logic [REQ_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ADDR_SIZE:0]     bin_q, bin_d;
    logic [ADDR_SIZE:0]     gray_q, gray_d;
    logic                   full_q, full_d;

    logic                   pick_vld;
    logic [REQ_ID_W-1:0]    pick_idx;
    logic                   sel_valid;
    logic                   sel_last;
    logic [DATA_SIZE-1:0]   sel_data;
    logic                   xfer;

    // Outer loop fixes rr_ptr so every requester index is a constant after unrolling.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int p = 0; p < NUM_REQ; p++) begin
            if (rr_ptr_q == REQ_ID_W'(p)) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!pick_vld && i_req_valid[(p + i) % NUM_REQ]) begin
                        pick_vld = 1'b1;
                        pick_idx = REQ_ID_W'((p + i) % NUM_REQ);
                    end
                end
            end
        end
    end

    always_comb begin
        sel_valid   = 1'b0;
        sel_last    = 1'b0;
        sel_data    = '0;
        o_req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q == REQ_ID_W'(k)) begin
                sel_valid      = i_req_valid[k];
                sel_last       = i_req_last[k];
                sel_data       = i_req_data[k*DATA_SIZE +: DATA_SIZE];
                o_req_ready[k] = (state_q == ST_LOCKED) && !full_q;
            end
        end
    end

    assign xfer = (state_q == ST_LOCKED) && sel_valid && !full_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (xfer && sel_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == REQ_ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Full is judged on the post-write pointer so the last free slot raises it in the same cycle.
    always_comb begin
        bin_d  = bin_q + {{ADDR_SIZE{1'b0}}, xfer};
        gray_d = bin_d ^ (bin_d >> 1);
        full_d = (gray_d == {~i_rd_gray_sync[ADDR_SIZE:ADDR_SIZE-1],
                             i_rd_gray_sync[ADDR_SIZE-2:0]});
    end

    always_ff @(posedge i_wr_clk or negedge i_wr_rst) begin
        if (!i_wr_rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            bin_q    <= '0;
            gray_q   <= '0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            bin_q    <= bin_d;
            gray_q   <= gray_d;
            full_q   <= full_d;
        end
    end

    assign o_wr_en    = xfer;
    assign o_wr_data  = sel_data;
    assign o_wr_addr  = bin_q[ADDR_SIZE-1:0];
    assign o_wr_gray  = gray_q;
    assign o_full     = full_q;
    assign o_grant_id = grant_q;
    assign o_busy     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboarded bench for fifo_wr_arbiter: per-requester beat queues feed the DUT,
// expected writes are queued in service order and popped as o_wr_en fires.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     i_req_valid;
    logic [NR-1:0]     i_req_last;
    logic [NR*DW-1:0]  i_req_data;
    logic [NR-1:0]     o_req_ready;
    logic [AW:0]       i_rd_gray_sync;
    logic              o_wr_en;
    logic [DW-1:0]     o_wr_data;
    logic [AW-1:0]     o_wr_addr;
    logic [AW:0]       o_wr_gray;
    logic              o_full;
    logic [IW-1:0]     o_grant_id;
    logic              o_busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .NUM_REQ(NR), .REQ_ID_W(IW)) dut (
        .i_wr_clk       (clk),
        .i_wr_rst       (rst_n),
        .i_req_valid    (i_req_valid),
        .i_req_last     (i_req_last),
        .i_req_data     (i_req_data),
        .o_req_ready    (o_req_ready),
        .i_rd_gray_sync (i_rd_gray_sync),
        .o_wr_en        (o_wr_en),
        .o_wr_data      (o_wr_data),
        .o_wr_addr      (o_wr_addr),
        .o_wr_gray      (o_wr_gray),
        .o_full         (o_full),
        .o_grant_id     (o_grant_id),
        .o_busy         (o_busy)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [IW-1:0] id;
    } exp_t;

    exp_t        sb[$];
    logic [DW:0] src[NR][$];
    int          checks = 0;
    int          errors = 0;
    logic [AW:0] exp_ptr = '0;
    logic [AW:0] mdl_bin = '0;

    // requester sources: hold each beat until it is accepted
    initial begin
        logic [NR-1:0] fire;
        logic [DW:0]   b;
        i_req_valid = '0;
        i_req_last  = '0;
        i_req_data  = '0;
        forever begin
            @(negedge clk);
            fire = i_req_valid & o_req_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < NR; k++) begin
                if (rst_n && fire[k] && src[k].size() > 0) void'(src[k].pop_front());
                if (src[k].size() > 0) begin
                    b = src[k][0];
                    i_req_valid[k] = 1'b1;
                    i_req_last[k]  = b[DW];
                    i_req_data[k*DW +: DW] = b[DW-1:0];
                end else begin
                    i_req_valid[k] = 1'b0;
                    i_req_last[k]  = 1'b0;
                    i_req_data[k*DW +: DW] = '0;
                end
            end
        end
    end

    // write monitor: scoreboard pop and Gray pointer model
    initial begin
        exp_t        e;
        logic [AW:0] g;
        forever begin
            @(negedge clk);
            g = mdl_bin ^ (mdl_bin >> 1);
            checks++;
            if (o_wr_gray !== g) begin
                errors++;
                $display("FAIL wr_gray got=%b exp=%b", o_wr_gray, g);
            end
            if (o_wr_en === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got addr=%0d data=%h id=%0d exp=none",
                             o_wr_addr, o_wr_data, o_grant_id);
                end else begin
                    e = sb.pop_front();
                    if (o_wr_addr !== e.addr || o_wr_data !== e.data || o_grant_id !== e.id) begin
                        errors++;
                        $display("FAIL write got addr=%0d data=%h id=%0d exp addr=%0d data=%h id=%0d",
                                 o_wr_addr, o_wr_data, o_grant_id, e.addr, e.data, e.id);
                    end
                end
                mdl_bin = mdl_bin + 1'b1;
            end
        end
    end

    task automatic queue_beats(input int k, input int n, input logic [DW-1:0] base, input bit end_last);
        logic [DW:0] b;
        for (int i = 0; i < n; i++) begin
            b[DW-1:0] = DW'(base + i);
            b[DW]     = end_last && (i == n - 1);
            src[k].push_back(b);
        end
    endtask

    task automatic expect_beats(input int k, input int n, input logic [DW-1:0] base);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = exp_ptr[AW-1:0];
            e.data = DW'(base + i);
            e.id   = IW'(k);
            sb.push_back(e);
            exp_ptr = exp_ptr + 1'b1;
        end
    endtask

    task automatic clear_models();
        for (int k = 0; k < NR; k++) src[k].delete();
        sb.delete();
        exp_ptr = '0;
        mdl_bin = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        i_rd_gray_sync = '0;
        clear_models();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int cyc = 0;
        while (sb.size() != 0 && cyc < limit) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s drain_timeout remaining=%0d exp=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_rd_gray_sync = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_wr_en !== 1'b0 || o_req_ready !== '0 || o_full !== 1'b0 ||
            o_grant_id !== '0 || o_wr_gray !== '0 || o_wr_addr !== '0) begin
            errors++;
            $display("FAIL reset_values got busy=%b en=%b rdy=%b full=%b gid=%0d gray=%b addr=%0d exp all zero",
                     o_busy, o_wr_en, o_req_ready, o_full, o_grant_id, o_wr_gray, o_wr_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b exp=0", o_busy);
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        queue_beats(2, 3, 8'hA1, 1'b1);
        expect_beats(2, 3, 8'hA1);
        @(negedge clk);
        #1;
        checks++;
        if (i_req_valid[2] !== 1'b1 || o_busy !== 1'b0 || o_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL arb_latency got busy=%b en=%b exp busy=0 en=0", o_busy, o_wr_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b1 || o_grant_id !== 2'd2 || o_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL grant2 got busy=%b gid=%0d rdy=%b exp busy=1 gid=2 rdy=0100",
                     o_busy, o_grant_id, o_req_ready);
        end
        wait_drain("single_req", 20);
        @(negedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_last got busy=%b en=%b exp 0 0", o_busy, o_wr_en);
        end
        // rr_ptr is now 3: requester 3 must beat requester 0
        queue_beats(0, 1, 8'h10, 1'b1);
        queue_beats(3, 1, 8'h30, 1'b1);
        expect_beats(3, 1, 8'h30);
        expect_beats(0, 1, 8'h10);
        wait_drain("rr_after_2", 20);
    endtask

    task automatic test_all_four();
        do_reset();
        for (int k = 0; k < NR; k++) queue_beats(k, 2, DW'(8'h40 + 16 * k), 1'b1);
        for (int k = 0; k < NR; k++) expect_beats(k, 2, DW'(8'h40 + 16 * k));
        wait_drain("all_four", 60);
    endtask

    task automatic test_valid_drop();
        int cyc = 0;
        do_reset();
        queue_beats(1, 2, 8'h50, 1'b0);
        queue_beats(3, 2, 8'h70, 1'b1);
        expect_beats(1, 2, 8'h50);
        while ((sb.size() != 0 || src[1].size() != 0) && cyc < 30) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (sb.size() != 0 || src[1].size() != 0) begin
            errors++;
            $display("FAIL drop_first_half timeout remaining=%0d exp=0", sb.size());
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            checks++;
            if (o_busy !== 1'b1 || o_grant_id !== 2'd1 || o_wr_en !== 1'b0 || o_req_ready[3] !== 1'b0) begin
                errors++;
                $display("FAIL grant_held got busy=%b gid=%0d en=%b rdy=%b exp busy=1 gid=1 en=0 rdy3=0",
                         o_busy, o_grant_id, o_wr_en, o_req_ready);
            end
        end
        queue_beats(1, 2, 8'h52, 1'b1);
        expect_beats(1, 2, 8'h52);
        expect_beats(3, 2, 8'h70);
        wait_drain("drop_resume", 30);
    endtask

    task automatic test_full();
        int cyc = 0;
        do_reset();
        queue_beats(0, 17, 8'h80, 1'b1);
        expect_beats(0, 17, 8'h80);
        while (sb.size() > 1 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            checks++;
            if (o_full !== 1'b1 || o_wr_gray !== 5'b11000 || o_req_ready !== '0 ||
                o_wr_en !== 1'b0 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL full_hold got full=%b gray=%b rdy=%b en=%b busy=%b exp 1 11000 0000 0 1",
                         o_full, o_wr_gray, o_req_ready, o_wr_en, o_busy);
            end
        end
        i_rd_gray_sync = 5'b00001;
        @(negedge clk);
        #1;
        checks++;
        if (o_full !== 1'b0 || o_wr_en !== 1'b1 || o_wr_addr !== 4'd0) begin
            errors++;
            $display("FAIL full_release got full=%b en=%b addr=%0d exp 0 1 0", o_full, o_wr_en, o_wr_addr);
        end
        wait_drain("full", 20);
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        queue_beats(2, 4, 8'hC0, 1'b1);
        expect_beats(2, 2, 8'hC0);
        wait_drain("pre_reset", 20);
        rst_n = 1'b0;
        clear_models();
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_wr_en !== 1'b0 || o_req_ready !== '0 || o_full !== 1'b0 ||
            o_grant_id !== '0 || o_wr_gray !== '0 || o_wr_addr !== '0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b en=%b rdy=%b full=%b gid=%0d gray=%b addr=%0d exp all zero",
                     o_busy, o_wr_en, o_req_ready, o_full, o_grant_id, o_wr_gray, o_wr_addr);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        queue_beats(1, 2, 8'hD0, 1'b1);
        expect_beats(1, 2, 8'hD0);
        wait_drain("post_reset", 20);
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int last  = -1;
        do_reset();
        for (int i = 0; i < 4; i++) queue_beats(0, 1, DW'(8'hE0 + i), 1'b1);
        for (int i = 0; i < 4; i++) expect_beats(0, 1, DW'(8'hE0 + i));
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (o_wr_en === 1'b1) begin
                if (first < 0) first = c;
                last = c;
            end
        end
        checks++;
        if (last - first != 6) begin
            errors++;
            $display("FAIL single_beat_rate got span=%0d exp=6", last - first);
        end
        wait_drain("back_to_back", 5);
    endtask

    task automatic test_wrap();
        int          cyc = 0;
        bit          saw_wrap = 0;
        logic [AW:0] prev = '0;
        logic [AW:0] cur;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            queue_beats(1, 8, DW'(p * 8), 1'b1);
            expect_beats(1, 8, DW'(p * 8));
        end
        while (sb.size() != 0 && cyc < 400) begin
            @(negedge clk);
            #1;
            cyc++;
            cur = o_wr_gray;
            i_rd_gray_sync = cur;
            checks++;
            if ($countones(cur ^ prev) > 1 || o_full !== 1'b0) begin
                errors++;
                $display("FAIL gray_step got prev=%b cur=%b full=%b exp one bit step full=0",
                         prev, cur, o_full);
            end
            if (prev == 5'b10000 && cur == 5'b00000) saw_wrap = 1;
            prev = cur;
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0 || !saw_wrap || o_wr_gray !== 5'b01100) begin
            errors++;
            $display("FAIL wrap got remaining=%0d wrapped=%0d gray=%b exp 0 1 01100",
                     sb.size(), saw_wrap, o_wr_gray);
        end
    endtask

    initial begin
        test_reset();
        test_single_requester();
        test_all_four();
        test_valid_drop();
        test_full();
        test_reset_mid_packet();
        test_back_to_back();
        test_wrap();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single write port of the async FIFO memory between NUM_REQ producers in the write clock domain.
- Owns the write pointer (binary address plus Gray pointer) and the registered full flag. The full flag is computed against the read Gray pointer, which arrives already synchronized into this domain.
- Drives the memory's write enable, write data and write address directly. The memory itself is not part of this block.

Parameters:
- DATA_SIZE, 8, width of each write data word.
- ADDR_SIZE, 4, memory address width; memory depth is 2^ADDR_SIZE.
- NUM_REQ, 4, number of requesters (2..8).
- REQ_ID_W, 2, width of grant index; must satisfy 2^REQ_ID_W >= NUM_REQ.

Ports:
- i_wr_clk  input  1  write-domain clock.
- i_wr_rst  input  1  asynchronous, active-low reset.
- i_req_valid  input  NUM_REQ  per-requester data valid.
- i_req_last  input  NUM_REQ  per-requester last beat of packet.
- i_req_data  input  NUM_REQ*DATA_SIZE  packed data; requester k occupies bits [k*DATA_SIZE +: DATA_SIZE].
- o_req_ready  output  NUM_REQ  per-requester ready; one-hot or zero.
- i_rd_gray_sync  input  ADDR_SIZE+1  read Gray pointer, already synchronized into i_wr_clk.
- o_wr_en  output  1  memory write strobe, already qualified by full.
- o_wr_data  output  DATA_SIZE  memory write data.
- o_wr_addr  output  ADDR_SIZE  memory write address.
- o_wr_gray  output  ADDR_SIZE+1  registered write Gray pointer, exported to the read-domain synchronizer.
- o_full  output  1  registered FIFO full.
- o_grant_id  output  REQ_ID_W  index of the current owner; valid only when o_busy = 1.
- o_busy  output  1  high while a grant is held.

Behaviour:
- Reset values (asynchronous, i_wr_rst = 0):
  - state IDLE, rr_ptr = 0, binary write pointer = 0, o_wr_gray = 0, o_full = 0.
  - o_grant_id = 0, o_busy = 0, o_req_ready = 0, o_wr_en = 0.
- State machine, two states:
  - IDLE: o_busy = 0, all ready low.
    - If any i_req_valid is high, pick the first valid index searching upward from rr_ptr, wrapping modulo NUM_REQ.
    - Register that index as o_grant_id and go to LOCKED.
    - Arbitration latency is one cycle: a request seen in cycle N can transfer no earlier than cycle N+1.
    - Arbitration does not depend on o_full.
  - LOCKED: o_busy = 1; g = o_grant_id.
    - o_req_ready[g] = !o_full; all other ready bits are 0.
    - Beat transfer = i_req_valid[g] & o_req_ready[g].
    - o_wr_en equals the transfer signal (combinational).
    - o_wr_data = slice g of i_req_data.
    - o_wr_addr = low ADDR_SIZE bits of the binary pointer.
    - On a transfer with i_req_last[g] = 1: go to IDLE and set rr_ptr = (g+1) mod NUM_REQ.
    - Otherwise stay LOCKED. The grant is held even if valid drops mid-packet; other requesters wait.
- Pointer arithmetic:
  - Binary pointer is ADDR_SIZE+1 bits and increments by 1 on each transfer, wrapping naturally from 2^(ADDR_SIZE+1)-1 to 0.
  - Gray pointer = bin_next ^ (bin_next >> 1), registered into o_wr_gray.
- Full flag:
  - o_full is registered.
  - Next value = (gray_next == {~i_rd_gray_sync[ADDR_SIZE:ADDR_SIZE-1], i_rd_gray_sync[ADDR_SIZE-2:0]}).
  - Full is detected in the same cycle the last free slot is written, so no write is ever issued while full.
  - o_full clears one cycle after i_rd_gray_sync changes so that the comparison is false.
- Boundary conditions:
  - Full during a packet: ready drops, the grant is held, and the packet resumes when space appears.
  - Single-beat packet (valid and last together): takes 1 IDLE cycle plus 1 LOCKED cycle, so back-to-back single beats reach at most 50% throughput.
  - All requesters valid: service order is rr_ptr, rr_ptr+1, and so on; no requester waits more than NUM_REQ-1 packets.
  - Reset mid-packet: everything returns to reset values. Beats already written stay in memory but are discarded, because the pointer returns to 0.
  - i_req_last on a non-granted requester is ignored.

Test Plan:
- Reset, then only requester 2 sends 3 beats (0xA1, 0xA2, 0xA3 with last) → grant_id = 2 one cycle after valid; o_wr_en for 3 cycles at addr 0, 1, 2; then IDLE with rr_ptr = 3.
- All 4 requesters each send a 2-beat packet, starting rr_ptr = 0 → service order 0, 1, 2, 3; write addresses 0..7 contiguous; no interleaving inside a packet.
- i_rd_gray_sync held at 0 while 16 beats are written → o_full = 1 in the cycle after the 16th write; o_wr_gray = 5'b11000; ready low; no further o_wr_en. Then set i_rd_gray_sync = 5'b00001 → o_full = 0 next cycle and the 17th beat is written at addr 0.
- Requester 1 drops valid for 3 cycles mid-packet while requester 3 is valid → grant stays 1; requester 3 is served only after requester 1's last beat.
- Assert i_wr_rst mid-packet after 2 beats → all outputs return to reset values immediately; the next packet writes from addr 0.
- Pointer wrap: stream 40 beats with the reader tracking, keeping it from going full → binary pointer wraps 31 → 0; the Gray pointer changes exactly one bit per write.
